// File: rtl/bpu_pkg.sv
// Shared types for the block-based BTB / bimodal branch predictor.
package bpu_pkg;

  // Widest partial tag an entry can hold; btb_predictor's TAG_BITS must not exceed it.
  localparam int unsigned BTB_TAG_W = 12;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_T    = 2'b10;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [1:0]           slot;
    logic [31:0]          target;
    ctr_t                 ctr;
  } btb_entry_t;

  typedef enum logic {StInit, StRun} fsm_e;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == CTR_STRONG_T) ? c : c + 2'd1;
    end
    return (c == CTR_STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// BTB storage: one synchronous read port for lookups, one write port, plus an
// asynchronous check port used by the update path for its read-modify-write.
// No reset on the array; the owner invalidates entries by sweeping the write port.
module btb_ram
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX     = $clog2(ENTRIES)
) (
  input  logic           i_clk,
  input  logic           i_rd_en,
  input  logic [IDX-1:0] i_rd_addr,
  output btb_entry_t     o_rd_data,
  input  logic           i_wr_en,
  input  logic [IDX-1:0] i_wr_addr,
  input  btb_entry_t     i_wr_data,
  input  logic [IDX-1:0] i_ck_addr,
  output btb_entry_t     o_ck_data
);

  btb_entry_t r_mem [ENTRIES];
  btb_entry_t r_rd_data;

  // Write and registered read share the edge, so a same-address read returns old contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_ck_data = r_mem[i_ck_addr];

endmodule

// File: rtl/btb_predictor.sv
// Block-based BTB with 2-bit bimodal counters. One entry per 16-byte fetch block;
// predicts the recorded branch if it sits at or after the fetch slot. Trained from EX.
module btb_predictor
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = BTB_TAG_W
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_lookup_valid,
  input  logic [31:0] i_lookup_pc,
  output logic [31:0] o_next_pc_predicted,
  output logic        o_prediction_valid,
  output logic [1:0]  o_pred_slot,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  output logic        o_init_done
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  // Partial tag sits directly above the index bits.
  function automatic logic [BTB_TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return BTB_TAG_W'((pc >> (4 + IDX)) & ((32'd1 << TAG_BITS) - 32'd1));
  endfunction

  fsm_e                 r_state, w_state_d;
  logic [IDX-1:0]       r_sweep_idx;
  logic                 r_init_done;

  logic                 r_lk_valid;
  logic [BTB_TAG_W-1:0] r_lk_tag;
  logic [1:0]           r_lk_slot;
  logic [31:0]          r_pc_hold;
  logic [1:0]           r_slot_hold;

  btb_entry_t           w_rd, w_ck, w_wr_data;
  logic                 w_wr_en;
  logic [IDX-1:0]       w_wr_addr;
  logic                 w_run, w_lk_fire, w_pred, w_upd_hit;
  logic [IDX-1:0]       w_upd_idx;
  logic [BTB_TAG_W-1:0] w_upd_tag;
  logic                 w_unused;

  assign w_run     = (r_state == StRun);
  assign w_lk_fire = i_lookup_valid && w_run && !i_flush;
  assign w_upd_idx = i_upd_pc[4 +: IDX];
  assign w_upd_tag = pc_tag(i_upd_pc);
  assign w_unused  = ^{i_lookup_pc[1:0], i_upd_pc[1:0], w_rd.ctr[0]};

  btb_ram #(
    .ENTRIES (ENTRIES),
    .IDX     (IDX)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rd_en   (w_lk_fire),
    .i_rd_addr (i_lookup_pc[4 +: IDX]),
    .o_rd_data (w_rd),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_ck_addr (w_upd_idx),
    .o_ck_data (w_ck)
  );

  // Next state: sweep every index once, then run forever (until reset).
  always_comb begin
    w_state_d = r_state;
    if (r_state == StInit && r_sweep_idx == IDX'(ENTRIES - 1)) begin
      w_state_d = StRun;
    end
  end

  // FSM state, sweep pointer and init_done flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StInit;
      r_sweep_idx <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StInit) begin
        r_sweep_idx <= r_sweep_idx + 1'b1;
      end
      r_init_done <= (w_state_d == StRun);
    end
  end

  assign o_init_done = r_init_done;

  // Lookup result in the cycle after the read; a flush in this cycle still kills it.
  assign w_pred = r_lk_valid && w_rd.valid && (w_rd.tag == r_lk_tag) && w_rd.ctr[1] &&
                  (w_rd.slot >= r_lk_slot) && !i_flush;

  assign o_prediction_valid  = w_pred;
  assign o_next_pc_predicted = w_pred ? w_rd.target : r_pc_hold;
  assign o_pred_slot         = w_pred ? w_rd.slot : r_slot_hold;

  // Lookup pipeline stage and held output values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lk_valid  <= 1'b0;
      r_lk_tag    <= '0;
      r_lk_slot   <= '0;
      r_pc_hold   <= '0;
      r_slot_hold <= '0;
    end else begin
      r_lk_valid <= w_lk_fire;
      if (w_lk_fire) begin
        r_lk_tag  <= pc_tag(i_lookup_pc);
        r_lk_slot <= i_lookup_pc[3:2];
      end
      if (w_pred) begin
        r_pc_hold   <= w_rd.target;
        r_slot_hold <= w_rd.slot;
      end
    end
  end

  assign w_upd_hit = w_ck.valid && (w_ck.tag == w_upd_tag) && (w_ck.slot == i_upd_pc[3:2]);

  // Write port: invalidation sweep during init, otherwise training from EX.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_upd_idx;
    w_wr_data = w_ck;
    if (!w_run) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_sweep_idx;
      w_wr_data = '0;
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        w_wr_en       = 1'b1;
        w_wr_data.ctr = ctr_next(w_ck.ctr, i_upd_taken);
        if (i_upd_taken) begin
          w_wr_data.target = i_upd_target;
        end
      end else if (i_upd_taken) begin
        w_wr_en          = 1'b1;
        w_wr_data.valid  = 1'b1;
        w_wr_data.tag    = w_upd_tag;
        w_wr_data.slot   = i_upd_pc[3:2];
        w_wr_data.target = i_upd_target;
        w_wr_data.ctr    = CTR_WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table, random traffic against
// a table model, init timing and mid-run reset.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] next_pc_predicted;
  logic        prediction_valid;
  logic [1:0]  pred_slot;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        init_done;

  always #5 clk = ~clk;

  btb_predictor #(
    .ENTRIES  (64),
    .TAG_BITS (12)
  ) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_flush             (flush),
    .i_lookup_valid      (lookup_valid),
    .i_lookup_pc         (lookup_pc),
    .o_next_pc_predicted (next_pc_predicted),
    .o_prediction_valid  (prediction_valid),
    .o_pred_slot         (pred_slot),
    .i_upd_valid         (upd_valid),
    .i_upd_pc            (upd_pc),
    .i_upd_taken         (upd_taken),
    .i_upd_target        (upd_target),
    .o_init_done         (init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one record per 16-byte block index, plain arithmetic on the PC.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_slot  [64];
  int unsigned m_tgt   [64];
  int unsigned m_ctr   [64];
  bit          m_pend;
  int unsigned m_pend_tgt, m_pend_slot;
  int unsigned m_hold_tgt, m_hold_slot;
  bit          s_pv;
  logic [31:0] s_pc;
  logic [1:0]  s_slot;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_pend      = 1'b0;
    m_hold_tgt  = 0;
    m_hold_slot = 0;
  endfunction

  function automatic bit model_predict(input int unsigned pc, output int unsigned tgt,
                                       output int unsigned slot);
    int unsigned i = (pc / 16) % 64;
    tgt  = m_tgt[i];
    slot = m_slot[i];
    return m_valid[i] && m_tag[i] == (pc / 1024) % 4096 && m_ctr[i] >= 2 &&
           m_slot[i] >= (pc / 4) % 4;
  endfunction

  function automatic void model_update(input int unsigned pc, input bit taken,
                                       input int unsigned tgt);
    int unsigned i = (pc / 16) % 64;
    int unsigned t = (pc / 1024) % 4096;
    int unsigned s = (pc / 4) % 4;
    if (m_valid[i] && m_tag[i] == t && m_slot[i] == s) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_slot[i]  = s;
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
  endfunction

  // One cycle, entered and left at posedge+1. Outputs checked mid-cycle reflect the
  // previous cycle's lookup and this cycle's flush.
  task automatic cycle(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit fl, input string nm);
    bit          exp_pv;
    int unsigned pt, ps;
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    flush        = fl;
    #2;
    exp_pv = m_pend && !fl;
    if (exp_pv) begin
      m_hold_tgt  = m_pend_tgt;
      m_hold_slot = m_pend_slot;
    end
    s_pv   = prediction_valid;
    s_pc   = next_pc_predicted;
    s_slot = pred_slot;
    check({nm, ".pv"}, {31'd0, prediction_valid}, {31'd0, exp_pv});
    check({nm, ".pc"}, next_pc_predicted, m_hold_tgt);
    check({nm, ".slot"}, {30'd0, pred_slot}, m_hold_slot);
    m_pend = lv && !fl && model_predict(lpc, pt, ps);
    m_pend_tgt  = pt;
    m_pend_slot = ps;
    if (uv) model_update(upc, ut, utgt);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          lv;
    logic [31:0] lpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    bit          fl;
    bit          epv;
    logic [31:0] epc;
    logic [1:0]  eslot;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit lv, input logic [31:0] lpc, input bit uv,
                              input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                              input bit fl, input bit epv, input logic [31:0] epc,
                              input logic [1:0] eslot);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.fl = fl; v.epv = epv; v.epc = epc; v.eslot = eslot;
    return v;
  endfunction

  task automatic do_reset_and_init(input string nm);
    reset = 1'b1;
    #1;
    check({nm, ".rst_pv"}, {31'd0, prediction_valid}, 32'd0);
    check({nm, ".rst_pc"}, next_pc_predicted, 32'd0);
    check({nm, ".rst_slot"}, {30'd0, pred_slot}, 32'd0);
    check({nm, ".rst_done"}, {31'd0, init_done}, 32'd0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (c >= 62) check($sformatf("%s.init_done@%0d", nm, c), {31'd0, init_done},
                         {31'd0, c >= 64});
      if (c == 1) check({nm, ".init_pv"}, {31'd0, prediction_valid}, 32'd0);
    end
  endtask

  initial begin
    flush = 0; lookup_valid = 0; lookup_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    #1;
    do_reset_and_init("init");

    // lv lpc uv upc ut utgt fl | epv epc eslot  (expectation = previous row's lookup)
    vecs.push_back(mk(0, 0,        1, 32'h1008, 1, 32'h2000, 0, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h1000, 0, 0,        0, 0,        0, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h100C, 0, 0,        0, 0,        0, 1, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        1, 32'h1008, 0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        1, 32'h1008, 0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(1, 32'h1000, 0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        1, 32'h1008, 1, 32'h2000, 0, 0, 32'h2000, 2));
    vecs.push_back(mk(1, 32'h1000, 0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        1, 32'h1008, 1, 32'h2000, 0, 0, 32'h2000, 2));
    vecs.push_back(mk(1, 32'h1000, 0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 1, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        1, 32'h1408, 1, 32'h3000, 0, 0, 32'h2000, 2));
    vecs.push_back(mk(1, 32'h1000, 0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(1, 32'h1400, 0, 0,        0, 0,        0, 0, 32'h2000, 2));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 1, 32'h3000, 2));
    vecs.push_back(mk(1, 32'h1050, 1, 32'h1054, 1, 32'h4000, 0, 0, 32'h3000, 2));
    vecs.push_back(mk(1, 32'h1050, 0, 0,        0, 0,        0, 0, 32'h3000, 2));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 1, 32'h4000, 1));
    vecs.push_back(mk(1, 32'h1050, 0, 0,        0, 0,        1, 0, 32'h4000, 1));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 0, 32'h4000, 1));
    vecs.push_back(mk(1, 32'h1050, 0, 0,        0, 0,        0, 0, 32'h4000, 1));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        1, 0, 32'h4000, 1));
    vecs.push_back(mk(0, 0,        0, 0,        0, 0,        0, 0, 32'h4000, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v = vecs[i];
      cycle(v.lv, v.lpc, v.uv, v.upc, v.ut, v.utgt, v.fl, $sformatf("vec%0d.model", i));
      check($sformatf("vec%0d.pv", i), {31'd0, s_pv}, {31'd0, v.epv});
      check($sformatf("vec%0d.pc", i), s_pc, v.epc);
      check($sformatf("vec%0d.slot", i), {30'd0, s_slot}, {30'd0, v.eslot});
    end

    // Random traffic over a few blocks so tags alias and counters move both ways.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lpc, upc, tgt;
      lpc = $urandom_range(0, 2) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4;
      upc = $urandom_range(0, 2) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4;
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle($urandom_range(0, 1) == 1, lpc, $urandom_range(0, 2) != 0, upc,
            $urandom_range(0, 2) != 0, tgt, $urandom_range(0, 7) == 0,
            $sformatf("rnd%0d", i));
    end

    // Reset while a prediction is pending: outputs clear at once, table is re-swept.
    cycle(0, 0, 1, 32'h1008, 1, 32'h2000, 0, "mr.train");
    cycle(1, 32'h1000, 0, 0, 0, 0, 0, "mr.look");
    lookup_valid = 0;
    upd_valid    = 0;
    do_reset_and_init("midrst");
    cycle(1, 32'h1000, 0, 0, 0, 0, 0, "mr.relook");
    cycle(0, 0, 0, 0, 0, 0, 0, "mr.after");
    check("mr.nopred", {31'd0, s_pv}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
